// File: rtl/lc3_boot_mem.sv
// rtl/lc3_boot_mem.sv - LC3 byte memory with a boot-time valid/ready image loader
// The processor is held in reset while the image streams in from address 0 upward.
module lc3_boot_mem #(
  parameter int ADDRESS_WIDTH = 8,
  parameter bit BOOT_LOAD     = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-1:0] address,
  input  logic [7:0]               data_in,
  input  logic                     write,
  output logic [7:0]               data_out,
  output logic                     cpu_hold,
  input  logic [7:0]               ld_data,
  input  logic                     ld_valid,
  input  logic                     ld_last,
  output logic                     ld_ready,
  output logic [ADDRESS_WIDTH:0]   ld_count
);

  localparam int DEPTH = 1 << ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] PTR_MAX = '1;
  localparam logic [ADDRESS_WIDTH-1:0] PTR_ONE = 1;
  localparam logic [ADDRESS_WIDTH:0]   CNT_ONE = 1;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_RELEASE,
    ST_RUN
  } state_t;

  localparam state_t ST_RESET = state_t'(BOOT_LOAD ? ST_LOAD : ST_RUN);

  logic [7:0]               mem_q [DEPTH];
  state_t                   state_q, state_d;
  logic                     ld_ready_q, ld_ready_d;
  logic [ADDRESS_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDRESS_WIDTH:0]   ld_count_q, ld_count_d;
  logic [7:0]               data_out_q, data_out_d;
  logic                     ld_fire;
  logic                     cpu_wr;

  assign ld_fire = (state_q == ST_LOAD) && ld_valid && ld_ready_q;
  assign cpu_wr  = (state_q == ST_RUN) && write;

  always_comb begin
    state_d    = state_q;
    ld_ready_d = 1'b0;
    ptr_d      = ptr_q;
    ld_count_d = ld_count_q;
    data_out_d = 8'h00;
    case (state_q)
      ST_LOAD: begin
        ld_ready_d = 1'b1;
        if (ld_fire) begin
          ptr_d      = ptr_q + PTR_ONE;
          ld_count_d = ld_count_q + CNT_ONE;
          // Dropping ready on the final beat guarantees nothing past it is taken.
          if (ld_last || (ptr_q == PTR_MAX)) begin
            state_d    = ST_RELEASE;
            ld_ready_d = 1'b0;
          end
        end
      end
      ST_RELEASE: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        data_out_d = mem_q[address];
      end
      default: begin
        state_d = ST_RESET;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_RESET;
      ld_ready_q <= 1'b0;
      ptr_q      <= '0;
      ld_count_q <= '0;
      data_out_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      ld_ready_q <= ld_ready_d;
      ptr_q      <= ptr_d;
      ld_count_q <= ld_count_d;
      data_out_q <= data_out_d;
    end
  end

  // Array is deliberately outside the reset domain so contents survive a reset.
  always_ff @(posedge clk) begin
    if (ld_fire) begin
      mem_q[ptr_q] <= ld_data;
    end else if (cpu_wr) begin
      mem_q[address] <= data_in;
    end
  end

  assign data_out = data_out_q;
  assign cpu_hold = (state_q != ST_RUN);
  assign ld_ready = ld_ready_q;
  assign ld_count = ld_count_q;

endmodule

// File: doc/lc3_boot_mem.md
Name: lc3_boot_mem

Overview:
- Byte-wide program/data memory on the LC3 memory bus.
- Consumes the processor's address, data_in and write, and returns data_out.
- After reset, holds the processor in reset and accepts a program image over a valid/ready byte-stream load port, writing it from address 0 upward.
- When the load completes, releases the processor and serves its reads and writes.

Parameters:
- ADDRESS_WIDTH, 8: width of the processor address bus. Memory depth is 2**ADDRESS_WIDTH bytes.
- BOOT_LOAD, 1: 1 = start in LOAD after reset; 0 = go straight to RUN (image preloaded by simulation).

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  reset, asynchronous, active-low.
- address  input  ADDRESS_WIDTH  processor memory address.
- data_in  input  8  processor write data.
- write  input  1  processor write strobe, active-high.
- data_out  output  8  read data to the processor.
- cpu_hold  output  1  active-high; holds the processor in reset.
- ld_data  input  8  load-stream byte.
- ld_valid  input  1  load byte valid.
- ld_last  input  1  marks the final byte of the image; qualified by ld_valid.
- ld_ready  output  1  load port can accept a byte.
- ld_count  output  ADDRESS_WIDTH+1  number of bytes loaded since reset.

Behaviour:
- Reset (rst low, asynchronous):
  - state = LOAD if BOOT_LOAD = 1, otherwise RUN.
  - data_out = 0, cpu_hold = 1 if BOOT_LOAD else 0, ld_ready = 0, ld_count = 0, load pointer = 0.
  - Memory array is not cleared.
- ld_ready is registered. It rises on the first posedge after rst deasserts, in LOAD only.
- States:
  - LOAD: ld_ready = 1, cpu_hold = 1.
    - On a posedge with ld_valid & ld_ready: mem[ptr] <= ld_data; ptr and ld_count increment.
    - Go to RELEASE if ld_last is set on that beat, or if ptr = 2**ADDRESS_WIDTH-1 (memory full).
    - On reaching RELEASE, ld_ready drops in the same edge, so no beat after the last is accepted.
    - ld_valid low: no change; the load may stall indefinitely.
    - Processor write and address are ignored; data_out holds 0.
  - RELEASE: exactly one cycle. cpu_hold = 1, ld_ready = 0, data_out = 0. Then RUN.
  - RUN: cpu_hold = 0, ld_ready = 0; the load port is ignored (ld_valid has no effect, ld_count frozen). Processor bus behaves as follows.
    - Read: data_out <= mem[address] each posedge. One-cycle latency: address presented before edge N gives data on data_out after edge N.
    - Write: write high at posedge stores mem[address] <= data_in.
    - Write and read at the same address on the same edge are read-first: data_out shows the old byte; the new byte is visible from the next edge.
    - RUN is left only by reset.
- ld_last on a non-valid cycle is ignored.
- ld_last on the beat that also fills the last address causes a single transition to RELEASE. ld_count = 2**ADDRESS_WIDTH (hence the extra bit).
- Reset mid-load returns to LOAD with ptr = 0 and ld_count = 0. Previously written bytes remain in memory and are overwritten by the new load.
- Reset in RUN re-enters LOAD (BOOT_LOAD = 1). cpu_hold asserts asynchronously with rst.
- ld_data, address and data_in have no X-propagation requirement outside the cycles in which they are qualified.

Test Plan:
1. Reset low 3 cycles, release; stream 0x11,0x22,0x33 with ld_last on 0x33 → ld_count = 3. cpu_hold stays 1 through RELEASE, deasserts the following cycle. In RUN, address 0,1,2 read back 0x11,0x22,0x33 with one-cycle latency.
2. Backpressure and gaps: ld_valid toggles 1,0,1,0 with bytes 0xA0,0xA1 and ld_last on 0xA1 → only 2 writes. ld_count = 2; mem[0] = 0xA0, mem[1] = 0xA1.
3. Full image, ADDRESS_WIDTH = 4: 16 bytes 0x00..0x0F with ld_last never asserted → enters RELEASE after the 16th byte. ld_ready = 0 afterwards; a 17th offered byte is not accepted; ld_count = 16.
4. RUN write/read collision: mem[5] = 0x55; write = 1, address = 5, data_in = 0xC3 → data_out after that edge = 0x55. Next cycle read of address 5 = 0xC3.
5. Reset mid-load: load 0xDE,0xAD, assert rst → cpu_hold = 1 and ld_count = 0 immediately. Reload 0xBE with ld_last → mem[0] = 0xBE, mem[1] still 0xAD.
6. BOOT_LOAD = 0: after reset, cpu_hold = 0 and ld_ready = 0. ld_valid with 0x77 has no effect; ld_count = 0. Processor write/read of address 0x10 returns the written value.
